nibble_deserializer: RTL and testbench
======================================

# nibble_deserializer

Upstream feeder for the 4-bit reduction-gate stage: collects a serial bit stream into 4-bit nibbles and presents each nibble on a registered valid/ready output. The output nibble drives the gate stage's 4-bit input directly. The block has no serial backpressure. A nibble that completes while the output buffer is occupied and not draining is dropped and flagged.

## Interface
- NIB_W, 4, nibble width; fixed at 4 and checked by elaboration assertion
- CNT_W, 8, width of delivered-nibble counter (only with NIBBLE_CNT_EN)
- Clock and reset: one clock; reset is asynchronous and active-high.
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous active-high reset
- clear  input  1  synchronous flush of partial nibble, output buffer and overflow flag
- bit_in  input  1  serial data bit
- bit_valid  input  1  bit_in is valid this cycle, always accepted
- nib_out  output  NIB_W  assembled nibble; first-received bit in nib_out[0]
- nib_valid  output  1  nib_out holds an undelivered nibble
- nib_ready  input  1  consumer accepts nib_out this cycle
- overflow  output  1  sticky: at least one completed nibble was dropped
- nib_count  output  CNT_W  nibbles delivered, wraps (only with NIBBLE_CNT_EN)

## Operation
- State: 3-bit shift holding register sr, 2-bit bit index idx, output register nib_out/nib_valid, overflow flag, optional counter.
- Bit accept: when bit_valid=1 and idx<3, sr[idx] gets bit_in and idx increments.
- Completion: when bit_valid=1 and idx=3, the completed nibble is {bit_in, sr[2:0]} and idx wraps to 0.
- Load rule: the completed nibble loads into nib_out and sets nib_valid=1 iff nib_valid=0 or nib_ready=1 in the same cycle.
- Drop: when completion happens with nib_valid=1 and nib_ready=0, the nibble is discarded, nib_out is unchanged and overflow is set to 1. idx still wraps to 0.
- Pop: on nib_valid=1 and nib_ready=1 with no completion, nib_valid goes to 0 and nib_out holds its last value.
- Simultaneous pop and completion: the new nibble loads and nib_valid stays 1. There is no bubble.
- nib_ready while nib_valid=0: ignored.
- clear has priority over all other updates: idx=0, nib_valid=0, overflow=0, count=0. A bit presented in the clear cycle is discarded. The nib_out value is don't-care.
- overflow is cleared only by rst or clear.
- nib_count increments on each handshake (nib_valid & nib_ready) and wraps 2^CNT_W-1 to 0.

## Timing
- Reset values: nib_out=0, nib_valid=0, overflow=0, nib_count=0, idx=0, sr=0.
- Latency: the fourth bit is accepted at edge N, and nib_valid=1 with the nibble is visible after edge N. That is a one-cycle registered output, with no combinational path from bit_in to nib_out.
- Throughput: one bit per cycle, so at most one nibble per 4 cycles. A consumer asserting nib_ready within 3 cycles of nib_valid never causes overflow.
- nib_out/nib_valid are stable while nib_valid=1 and nib_ready=0, except under clear.
- Reset asserted mid-nibble: the partial bits are lost, and the next accepted bit becomes nib_out[0].
- No state machine beyond idx (0→1→2→3→0, advancing only on bit_valid).

## Configuration
- NIBBLE_CNT_EN defined: the nib_count port and counter are present, with behaviour as above.
- NIBBLE_CNT_EN undefined: the nib_count port is absent and no counter logic is built. All other behaviour is identical.

## Structure
- Shared package: NIB_W constant, nib_t (logic [NIB_W-1:0]) typedef, and the idx_t (2-bit) typedef.
- There is no sub-module. The design is a single module with one always_ff on clk/rst and small combinational completion/load decode.

## Test plan
- Bits 1,0,1,1 on 4 consecutive cycles with nib_ready=1 → nib_out=4'b1101 and nib_valid=1 one cycle after the 4th bit; nib_count=1 after the handshake.
- Gapped bits (bit_valid 1,0,1,0,1,0,1 with data 0,1,1,0) → nib_out=4'b0110. Gaps do not reset idx.
- nib_ready=0 held with 8 bits streamed (nibbles 0xA then 0x5) → nib_out stays 0xA and overflow=1; after nib_ready=1, one handshake occurs and nib_valid drops.
- Back-to-back stream 0x3,0xC with nib_ready=1 on the completion cycle of the second → nib_valid stays 1 continuously and nib_out changes 0x3→0xC.
- 2 bits sent, then clear, then bits 1,1,1,0 → nib_out=4'b0111; overflow=0 and count=0 after clear.
- rst asserted asynchronously mid-nibble and mid-valid → all outputs 0 immediately; 256 handshakes with NIBBLE_CNT_EN defined → nib_count wraps to 0.

Source files
------------

// File: rtl/nibble_deserializer_pkg.sv
// Shared types for the nibble deserializer: nibble width, nibble and bit-index types.
package nibble_deserializer_pkg;

  localparam int NIB_W = 4;
  localparam int CNT_W = 8;

  typedef logic [NIB_W-1:0] nib_t;
  typedef logic [1:0]       idx_t;

endpackage

// File: rtl/nibble_deserializer_if.sv
// Serial input and registered nibble output of the deserializer.
// The slave modport is the deserializer; the master modport is its environment.
interface nibble_deserializer_if;
  import nibble_deserializer_pkg::*;

  logic bit_in;
  logic bit_valid;
  nib_t nib_out;
  logic nib_valid;
  logic nib_ready;

  modport slave (
    input  bit_in,
    input  bit_valid,
    input  nib_ready,
    output nib_out,
    output nib_valid
  );

  modport master (
    output bit_in,
    output bit_valid,
    output nib_ready,
    input  nib_out,
    input  nib_valid
  );

endinterface

// File: rtl/nibble_deserializer.sv
// Collects a serial bit stream into nibbles on a registered valid/ready output.
// Build option: define NIBBLE_CNT_EN to add the nib_count delivered-nibble counter.
module nibble_deserializer
  import nibble_deserializer_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  nibble_deserializer_if.slave  bus,
  output logic                  overflow
`ifdef NIBBLE_CNT_EN
  , output logic [CNT_W-1:0]    nib_count
`endif
);

  if (NIB_W != 4 || CNT_W < 1) begin : g_param_check
    $error("nibble_deserializer: NIB_W must be 4 and CNT_W at least 1");
  end

  logic [2:0] sr;
  idx_t       idx;
  nib_t       nib_q;
  logic       valid_q;

  logic complete;
  logic load;
  logic pop;

  // The last bit completes the nibble; it may only load if the buffer is empty or draining.
  assign complete = bus.bit_valid && (idx == 2'd3);
  assign load     = complete && (!valid_q || bus.nib_ready);
  assign pop      = valid_q && bus.nib_ready;

  assign bus.nib_out   = nib_q;
  assign bus.nib_valid = valid_q;

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr       <= '0;
      idx      <= '0;
      nib_q    <= '0;
      valid_q  <= 1'b0;
      overflow <= 1'b0;
    end else if (clear) begin
      idx      <= '0;
      valid_q  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (bus.bit_valid) begin
        if (idx != 2'd3) sr[idx] <= bus.bit_in;
        idx <= idx + 2'd1;
      end
      if (load) begin
        nib_q   <= {bus.bit_in, sr};
        valid_q <= 1'b1;
      end else if (pop) begin
        valid_q <= 1'b0;
      end
      if (complete && !load) overflow <= 1'b1;
    end
  end

`ifdef NIBBLE_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        nib_count <= '0;
    else if (clear) nib_count <= '0;
    else if (pop)   nib_count <= nib_count + CNT_W'(1);
  end
`endif

endmodule

// File: tb/tb_nibble_deserializer.sv
// Self-checking bench: directed scenarios plus random traffic against a bit-list model.
module tb_nibble_deserializer;
  import nibble_deserializer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clear = 1'b0;
  logic overflow;
`ifdef NIBBLE_CNT_EN
  logic [CNT_W-1:0] nib_count;
`endif

  nibble_deserializer_if bus();

  nibble_deserializer dut (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .bus      (bus),
    .overflow (overflow)
`ifdef NIBBLE_CNT_EN
    , .nib_count(nib_count)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: accumulate accepted bits arithmetically, deliver every fourth.
  int   m_nbits;
  int   m_partial;
  int   m_out;
  bit   m_valid;
  bit   m_ovf;
  int   m_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_nbits = 0; m_partial = 0; m_out = 0; m_valid = 0; m_ovf = 0; m_cnt = 0;
    end else if (clear) begin
      m_nbits = 0; m_partial = 0; m_valid = 0; m_ovf = 0; m_cnt = 0;
    end else begin
      bit done;
      bit popped;
      int fresh;
      done = 0;
      fresh = 0;
      popped = m_valid && bus.nib_ready;
      if (bus.bit_valid) begin
        m_partial = m_partial + (int'(bus.bit_in) << m_nbits);
        m_nbits++;
        if (m_nbits == 4) begin
          done = 1; fresh = m_partial; m_partial = 0; m_nbits = 0;
        end
      end
      if (done) begin
        if (!m_valid || bus.nib_ready) begin
          m_out = fresh; m_valid = 1;
        end else begin
          m_ovf = 1;
        end
      end else if (popped) begin
        m_valid = 0;
      end
      if (popped) m_cnt = (m_cnt + 1) % (1 << CNT_W);
    end
  end

  always @(negedge clk) begin
    check("valid", 32'(bus.nib_valid), 32'(m_valid));
    check("overflow", 32'(overflow), 32'(m_ovf));
    if (m_valid) check("nib_out", 32'(bus.nib_out), 32'(m_out));
`ifdef NIBBLE_CNT_EN
    check("count", 32'(nib_count), 32'(m_cnt));
`endif
  end

  // Inputs change on the falling edge, are consumed at the next rising edge,
  // and the task returns on the following falling edge.
  task automatic step(input logic bv, input logic b, input logic rdy, input logic clr);
    bus.bit_valid = bv;
    bus.bit_in    = b;
    bus.nib_ready = rdy;
    clear         = clr;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_nib(input logic [3:0] val, input logic [3:0] rdy);
    for (int i = 0; i < 4; i++) step(1'b1, val[i], rdy[i], 1'b0);
  endtask

  initial begin
    bus.bit_valid = 1'b0;
    bus.bit_in    = 1'b0;
    bus.nib_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out", 32'(bus.nib_out), 32'h0);
    check("rst_valid", 32'(bus.nib_valid), 32'h0);
    check("rst_ovf", 32'(overflow), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Bits 1,0,1,1 -> 4'b1101, then handshake.
    send_nib(4'b1101, 4'b1111);
    check("t1_valid", 32'(bus.nib_valid), 32'h1);
    check("t1_out", 32'(bus.nib_out), 32'hD);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("t1_pop", 32'(bus.nib_valid), 32'h0);
`ifdef NIBBLE_CNT_EN
    check("t1_count", 32'(nib_count), 32'h1);
`endif

    // Gapped bits 0,1,1,0.
    step(1'b1, 1'b0, 1'b0, 1'b0); step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0); step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("t2_out", 32'(bus.nib_out), 32'h6);
    step(1'b0, 1'b0, 1'b1, 1'b0);

    // Stalled consumer: 0xA held, 0x5 dropped.
    send_nib(4'hA, 4'b0000);
    send_nib(4'h5, 4'b0000);
    check("t3_out", 32'(bus.nib_out), 32'hA);
    check("t3_ovf", 32'(overflow), 32'h1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("t3_pop", 32'(bus.nib_valid), 32'h0);

    // Back-to-back 0x3 then 0xC with pop on the completion cycle.
    send_nib(4'h3, 4'b0000);
    check("t4_first", 32'(bus.nib_out), 32'h3);
    send_nib(4'hC, 4'b1000);
    check("t4_valid", 32'(bus.nib_valid), 32'h1);
    check("t4_second", 32'(bus.nib_out), 32'hC);
    step(1'b0, 1'b0, 1'b1, 1'b0);

    // Partial nibble flushed by clear.
    step(1'b1, 1'b0, 1'b0, 1'b0); step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    check("t5_ovf_clr", 32'(overflow), 32'h0);
`ifdef NIBBLE_CNT_EN
    check("t5_cnt_clr", 32'(nib_count), 32'h0);
`endif
    send_nib(4'b0111, 4'b0000);
    check("t5_out", 32'(bus.nib_out), 32'h7);

    // Async reset mid-nibble, mid-valid, with overflow set.
    send_nib(4'hF, 4'b0000);
    step(1'b1, 1'b1, 1'b0, 1'b0); step(1'b1, 1'b1, 1'b0, 1'b0);
    check("t6_ovf_pre", 32'(overflow), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("t6_out", 32'(bus.nib_out), 32'h0);
    check("t6_valid", 32'(bus.nib_valid), 32'h0);
    check("t6_ovf", 32'(overflow), 32'h0);
`ifdef NIBBLE_CNT_EN
    check("t6_count", 32'(nib_count), 32'h0);
`endif
    @(negedge clk);
    rst = 1'b0;
    send_nib(4'h1, 4'b0000);
    check("t6_after", 32'(bus.nib_out), 32'h1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 199) == 0));
    end

`ifdef NIBBLE_CNT_EN
    // Counter wrap after 256 handshakes.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 256; i++) send_nib(4'($urandom), 4'b1111);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("wrap_count", 32'(nib_count), 32'h0);
`endif

    step(1'b0, 1'b0, 1'b0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
